// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the sequential multi-channel BCD converter.
// Imported by the handshake top and by every dabble lane.
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_W = 4;

    function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    function automatic logic [BCD_W-1:0] sat_digit();
        return 4'd9;
    endfunction

endpackage

// File: rtl/bcd_seq_multi_if.sv
// Request/result bundle between a host and bcd_seq_multi.
// The host drives start/bin_in; the converter returns handshake and BCD results.
interface bcd_seq_multi_if #(
    parameter int IN_W  = 14,
    parameter int N_DIG = 4,
    parameter int N_CH  = 4
);

    logic                      start;
    logic [N_CH*IN_W-1:0]      bin_in;
    logic                      busy;
    logic                      done;
    logic [N_CH*N_DIG*4-1:0]   bcd_out;
    logic [N_CH*N_DIG-1:0]     lz_mask;
    logic [N_CH-1:0]           overflow;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  lz_mask,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output lz_mask,
        output overflow
    );

endinterface

// File: rtl/bcd_dabble_lane.sv
// One channel of the double-dabble engine: binary shifter, BCD scratch, sticky
// overflow, and the result registers that only change on commit or reset.
module bcd_dabble_lane
    import bcd_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int N_DIG = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic                     shift_i,
    input  logic                     commit_i,
    input  logic [IN_W-1:0]          bin_i,
    output logic [N_DIG*BCD_W-1:0]   bcd_o,
    output logic [N_DIG-1:0]         lz_o,
    output logic                     ovf_o
);

    localparam int SW = N_DIG * BCD_W;
    localparam logic [N_DIG-1:0] LZ_RST = ~N_DIG'(1);

    logic [IN_W-1:0]  bin_q,     bin_d;
    logic [SW-1:0]    scratch_q, scratch_d;
    logic             sticky_q,  sticky_d;
    logic [SW-1:0]    adj;
    logic [SW-1:0]    final_bcd;
    logic [N_DIG-1:0] final_lz;
    logic [SW-1:0]    bcd_q;
    logic [N_DIG-1:0] lz_q;
    logic             ovf_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_adj
            assign adj[gi*BCD_W +: BCD_W] = add3_adjust(scratch_q[gi*BCD_W +: BCD_W]);
        end
    endgenerate

    // A 1 leaving the top adjusted digit means the prefix no longer fits N_DIG digits.
    always_comb begin
        bin_d     = bin_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        if (load_i) begin
            bin_d     = bin_i;
            scratch_d = '0;
            sticky_d  = 1'b0;
        end else if (shift_i) begin
            bin_d     = bin_q << 1;
            scratch_d = {adj[SW-2:0], bin_q[IN_W-1]};
            sticky_d  = sticky_q | adj[SW-1];
        end
    end

    assign final_bcd = sticky_d ? {N_DIG{sat_digit()}} : scratch_d;

    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_lz
            if (gi == 0) begin : g_ones
                assign final_lz[gi] = 1'b0;
            end else begin : g_upper
                assign final_lz[gi] = (final_bcd[SW-1:gi*BCD_W] == '0);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q     <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            bcd_q     <= '0;
            lz_q      <= LZ_RST;
            ovf_q     <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            if (commit_i) begin
                bcd_q <= final_bcd;
                lz_q  <= final_lz;
                ovf_q <= sticky_d;
            end
        end
    end

    assign bcd_o = bcd_q;
    assign lz_o  = lz_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/bcd_seq_multi.sv
// Multi-channel binary-to-BCD converter, one input bit per clock on all lanes.
// Holds the start/busy/done handshake, the bit counter and the lane array.
module bcd_seq_multi
    import bcd_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int N_DIG = 4,
    parameter int N_CH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_seq_multi_if.slave    bus
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);
    localparam int LW = N_DIG * BCD_W;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             load, shift, commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // The final shift and the result commit happen on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_lane
            bcd_dabble_lane #(
                .IN_W  (IN_W),
                .N_DIG (N_DIG)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_i   (load),
                .shift_i  (shift),
                .commit_i (commit),
                .bin_i    (bus.bin_in[gi*IN_W +: IN_W]),
                .bcd_o    (bus.bcd_out[gi*LW +: LW]),
                .lz_o     (bus.lz_mask[gi*N_DIG +: N_DIG]),
                .ovf_o    (bus.overflow[gi])
            );
        end
    endgenerate

endmodule
